// File: rtl/addsub_serial_ctrl_if.sv
// Start/done handshake and operand/result bundle for the chunk-serial add/sub sequencer.
// The zero port exists only when ZERO_FLAG_EN is defined.
interface addsub_serial_ctrl_if #(
   parameter int N = 8
);
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         cout;
   logic         overflow;
`ifdef ZERO_FLAG_EN
   logic         zero;

   modport master (output start, op, a, b, input busy, done, result, cout, overflow, zero);
   modport slave  (input start, op, a, b, output busy, done, result, cout, overflow, zero);
`else
   modport master (output start, op, a, b, input busy, done, result, cout, overflow);
   modport slave  (input start, op, a, b, output busy, done, result, cout, overflow);
`endif
endinterface

// File: rtl/addsub_serial_ctrl.sv
// Chunk-serial NOT/NEG/SUB/ADD sequencer: N-bit operands processed LSB-first, W bits per cycle.
// Optional zero flag is built when ZERO_FLAG_EN is defined.
module addsub_serial_ctrl #(
   parameter int N = 8,
   parameter int W = 2
) (
   input logic                clk,
   input logic                rst,
   addsub_serial_ctrl_if.slave bus
);
   localparam int CHUNKS = N / W;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

   localparam logic [1:0] OP_NOT = 2'b00;
   localparam logic [1:0] OP_NEG = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_reg;
   logic [1:0]    op_reg;
   logic [N-1:0]  x_reg;
   logic [N-1:0]  y_reg;
   logic [N-1:0]  acc_reg;
   logic          carry_reg;
   logic [CW-1:0] cnt_reg;
   logic          busy_reg;
   logic          done_reg;
   logic [N-1:0]  result_reg;
   logic          cout_reg;
   logic          overflow_reg;
`ifdef ZERO_FLAG_EN
   logic          zero_reg;
`endif

   logic [W-1:0] x_chunk;
   logic [W-1:0] y_chunk;
   logic [W:0]   chunk_sum;
   logic         carry_into_msb;
   logic [N-1:0] acc_next;
   int           base;

   always_comb begin
      base           = int'(cnt_reg) * W;
      x_chunk        = x_reg[base +: W];
      y_chunk        = y_reg[base +: W];
      chunk_sum      = {1'b0, x_chunk} + {1'b0, y_chunk} + {{W{1'b0}}, carry_reg};
      // Recover the carry into the top bit from the sum bit and its two addend bits.
      carry_into_msb = chunk_sum[W-1] ^ x_chunk[W-1] ^ y_chunk[W-1];
      acc_next       = acc_reg;
      acc_next[base +: W] = chunk_sum[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         op_reg       <= OP_NOT;
         x_reg        <= '0;
         y_reg        <= '0;
         acc_reg      <= '0;
         carry_reg    <= 1'b0;
         cnt_reg      <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         result_reg   <= '0;
         cout_reg     <= 1'b0;
         overflow_reg <= 1'b0;
`ifdef ZERO_FLAG_EN
         zero_reg     <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  op_reg   <= bus.op;
                  acc_reg  <= '0;
                  cnt_reg  <= '0;
                  busy_reg <= 1'b1;
                  state_reg <= RUN;
                  case (bus.op)
                     OP_NOT: begin x_reg <= '0;    y_reg <= ~bus.a; carry_reg <= 1'b0; end
                     OP_NEG: begin x_reg <= '0;    y_reg <= ~bus.a; carry_reg <= 1'b1; end
                     OP_SUB: begin x_reg <= bus.a; y_reg <= ~bus.b; carry_reg <= 1'b1; end
                     default: begin x_reg <= bus.a; y_reg <= bus.b; carry_reg <= 1'b0; end
                  endcase
               end
            end
            RUN: begin
               acc_reg   <= acc_next;
               carry_reg <= chunk_sum[W];
               cnt_reg   <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_CHUNK) begin
                  // Result and flags are only ever written here, so no partial value is visible.
                  result_reg   <= acc_next;
                  cout_reg     <= (op_reg != OP_NOT) & chunk_sum[W];
                  overflow_reg <= (op_reg != OP_NOT) & (carry_into_msb ^ chunk_sum[W]);
`ifdef ZERO_FLAG_EN
                  zero_reg     <= (acc_next == '0);
`endif
                  done_reg     <= 1'b1;
                  state_reg    <= DONE;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
   assign bus.result   = result_reg;
   assign bus.cout     = cout_reg;
   assign bus.overflow = overflow_reg;
`ifdef ZERO_FLAG_EN
   assign bus.zero     = zero_reg;
`endif
endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Bench for addsub_serial_ctrl: W=2 and W=8 instances driven in parallel, directed table,
// random ops against an arithmetic reference, plus busy re-start and mid-run reset sequences.
module tb_addsub_serial_ctrl;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   addsub_serial_ctrl_if #(.N(N)) bus2 ();
   addsub_serial_ctrl_if #(.N(N)) bus8 ();

   addsub_serial_ctrl #(.N(N), .W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
   addsub_serial_ctrl #(.N(N), .W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       cout;
      logic       ovf;
      logic       zero;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference built from the arithmetic meaning of each op, not from chunking.
   function automatic vec_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      vec_t v;
      int   s;
      v.op = op; v.a = a; v.b = b;
      case (op)
         2'b00: begin v.res = ~a; v.cout = 1'b0; v.ovf = 1'b0; end
         2'b01: begin
            s = 256 - int'(a);
            v.res = s[7:0]; v.cout = (a == 8'h00); v.ovf = (a == 8'h80);
         end
         2'b10: begin
            s = int'(a) - int'(b);
            v.res = s[7:0]; v.cout = (a >= b);
            v.ovf = (a[7] != b[7]) && (v.res[7] != a[7]);
         end
         default: begin
            s = int'(a) + int'(b);
            v.res = s[7:0]; v.cout = s[8];
            v.ovf = (a[7] == b[7]) && (v.res[7] != a[7]);
         end
      endcase
      v.zero = (v.res == 8'h00);
      return v;
   endfunction

   task automatic run_both(input string tag, input vec_t e);
      logic [7:0] pre2, pre8, r2, r8;
      logic       c2, c8, o2, o8, bz2, bz8;
`ifdef ZERO_FLAG_EN
      logic       z2, z8;
`endif
      int lat2, lat8;
      bit got2, got8, stable;
      pre2 = bus2.result; pre8 = bus8.result;
      got2 = 0; got8 = 0; stable = 1; lat2 = 0; lat8 = 0;
      r2 = '0; r8 = '0; c2 = 0; c8 = 0; o2 = 0; o8 = 0; bz2 = 0; bz8 = 0;
`ifdef ZERO_FLAG_EN
      z2 = 0; z8 = 0;
`endif
      @(negedge clk);
      bus2.start = 1'b1; bus2.op = e.op; bus2.a = e.a; bus2.b = e.b;
      bus8.start = 1'b1; bus8.op = e.op; bus8.a = e.a; bus8.b = e.b;
      @(posedge clk); #1;
      bus2.start = 1'b0; bus8.start = 1'b0;
      // Scramble operands after accept: the latched copies must be used.
      bus2.a = 8'($urandom); bus2.b = 8'($urandom);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      for (int c = 1; c <= 20 && !(got2 && got8); c++) begin
         @(posedge clk); #1;
         if (!got2) begin
            if (bus2.done) begin
               got2 = 1; lat2 = c + 1; r2 = bus2.result; c2 = bus2.cout;
               o2 = bus2.overflow; bz2 = bus2.busy;
`ifdef ZERO_FLAG_EN
               z2 = bus2.zero;
`endif
            end else if (bus2.result !== pre2) stable = 0;
         end
         if (!got8) begin
            if (bus8.done) begin
               got8 = 1; lat8 = c + 1; r8 = bus8.result; c8 = bus8.cout;
               o8 = bus8.overflow; bz8 = bus8.busy;
`ifdef ZERO_FLAG_EN
               z8 = bus8.zero;
`endif
            end else if (bus8.result !== pre8) stable = 0;
         end
      end
      check({tag, " done_w2"}, 32'(got2), 1);
      check({tag, " done_w8"}, 32'(got8), 1);
      check({tag, " no_partial"}, 32'(stable), 1);
      if (got2) begin
         check({tag, " res_w2"}, 32'(r2), 32'(e.res));
         check({tag, " cout_w2"}, 32'(c2), 32'(e.cout));
         check({tag, " ovf_w2"}, 32'(o2), 32'(e.ovf));
         check({tag, " busy_at_done_w2"}, 32'(bz2), 1);
         check({tag, " lat_w2"}, 32'(lat2), 5);
`ifdef ZERO_FLAG_EN
         check({tag, " zero_w2"}, 32'(z2), 32'(e.zero));
`endif
      end
      if (got8) begin
         check({tag, " res_w8"}, 32'(r8), 32'(e.res));
         check({tag, " cout_w8"}, 32'(c8), 32'(e.cout));
         check({tag, " ovf_w8"}, 32'(o8), 32'(e.ovf));
         check({tag, " lat_w8"}, 32'(lat8), 2);
`ifdef ZERO_FLAG_EN
         check({tag, " zero_w8"}, 32'(z8), 32'(e.zero));
`endif
      end
      @(posedge clk); #1;
      check({tag, " done_pulse_w2"}, 32'(bus2.done), 0);
      check({tag, " idle_busy_w2"}, 32'(bus2.busy), 0);
      check({tag, " hold_w2"}, 32'(bus2.result), 32'(e.res));
      check({tag, " hold_w8"}, 32'(bus8.result), 32'(e.res));
      $display("txn %s op=%0d a=%02h b=%02h w2: res=%02h c=%0d v=%0d lat=%0d | w8: res=%02h lat=%0d",
               tag, e.op, e.a, e.b, r2, c2, o2, lat2, r8, lat8);
   endtask

   initial begin
      int  lat;
      bit  got, saw;
      vec_t v;

      tbl[0] = '{2'b11, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{2'b10, 8'd5,   8'd7,  8'hFE,  1'b0, 1'b0, 1'b0};
      tbl[2] = '{2'b10, 8'd7,   8'd5,  8'h02,  1'b1, 1'b0, 1'b0};
      tbl[3] = '{2'b01, 8'h80,  8'h33, 8'h80,  1'b0, 1'b1, 1'b0};
      tbl[4] = '{2'b01, 8'h01,  8'hC4, 8'hFF,  1'b0, 1'b0, 1'b0};
      tbl[5] = '{2'b00, 8'hA5,  8'h3C, 8'h5A,  1'b0, 1'b0, 1'b0};
      tbl[6] = '{2'b11, 8'd127, 8'd1,  8'h80,  1'b0, 1'b1, 1'b0};
      tbl[7] = '{2'b11, 8'hFF,  8'h01, 8'h00,  1'b1, 1'b0, 1'b1};
      tbl[8] = '{2'b01, 8'h00,  8'h77, 8'h00,  1'b1, 1'b0, 1'b1};
      tbl[9] = '{2'b10, 8'h80,  8'h01, 8'h7F,  1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      bus2.start = 1'b0; bus2.op = 2'b00; bus2.a = '0; bus2.b = '0;
      bus8.start = 1'b0; bus8.op = 2'b00; bus8.a = '0; bus8.b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 32'(bus2.busy), 0);
      check("rst done", 32'(bus2.done), 0);
      check("rst result", 32'(bus2.result), 0);
      check("rst cout", 32'(bus2.cout), 0);
      check("rst overflow", 32'(bus2.overflow), 0);
      check("rst result_w8", 32'(bus8.result), 0);
`ifdef ZERO_FLAG_EN
      check("rst zero", 32'(bus2.zero), 0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_both($sformatf("tbl%0d", i), tbl[i]);

      for (int i = 0; i < 30; i++) begin
         v = model(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
         run_both($sformatf("rnd%0d", i), v);
      end

      // start re-pulsed with other operands while busy must be ignored
      @(negedge clk);
      bus2.start = 1'b1; bus2.op = 2'b11; bus2.a = 8'd100; bus2.b = 8'd27;
      @(posedge clk); #1;
      bus2.op = 2'b10; bus2.a = 8'd5; bus2.b = 8'd7;
      got = 0; lat = 0;
      for (int c = 1; c <= 20 && !got; c++) begin
         @(posedge clk); #1;
         if (c == 2) bus2.start = 1'b0;
         if (bus2.done) begin got = 1; lat = c + 1; end
      end
      check("busy_restart done", 32'(got), 1);
      check("busy_restart lat", 32'(lat), 5);
      check("busy_restart result", 32'(bus2.result), 127);
      check("busy_restart cout", 32'(bus2.cout), 0);
      $display("txn busy_restart res=%02h lat=%0d", bus2.result, lat);
      @(posedge clk); #1;
      check("busy_restart idle", 32'(bus2.busy), 0);

      // reset during the third RUN cycle
      @(negedge clk);
      bus2.start = 1'b1; bus2.op = 2'b11; bus2.a = 8'd3; bus2.b = 8'd4;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midrun busy", 32'(bus2.busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrun_rst busy", 32'(bus2.busy), 0);
      check("midrun_rst done", 32'(bus2.done), 0);
      check("midrun_rst result", 32'(bus2.result), 0);
      check("midrun_rst cout", 32'(bus2.cout), 0);
      check("midrun_rst result_w8", 32'(bus8.result), 0);
      saw = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (bus2.done || bus2.busy) saw = 1;
      end
      check("midrun_rst no_done", 32'(saw), 0);
      $display("txn midrun_rst busy=%0d result=%02h", bus2.busy, bus2.result);

      run_both("after_rst", tbl[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
